brlite_tx_arbiter: RTL and testbench
====================================

# brlite_tx_arbiter

Round-robin scheduler sharing the single BrLite output port between `N_REQ` service producers, such as the CPU-driven service send path and the monitor publishers. It latches the winning requester's packet and drives the BrLite req/ack handshake. It returns a one-cycle acknowledge to the winning requester and enforces a programmable idle gap between consecutive broadcasts. It sits between the producers and the BrLite router local port.

## Interface
Parameters:
- `N_REQ`, default 3: number of requesters; legal range ≥ 2.
- `MIN_GAP`, default 2: idle cycles inserted after each completed broadcast; legal range 0..255.

Ports:
- `clk_i`  in  1  single clock; all logic on its rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_i`  in  N_REQ  per-requester send request; level.
- `data_i`  in  N_REQ × brlite_out_t  per-requester packet (service, ksvc, seq_target, producer, payload).
- `ack_o`  out  N_REQ  one-cycle pulse: packet of that requester accepted by router.
- `grant_o`  out  N_REQ  one-hot; index currently owning the port; 0 when no owner.
- `busy_o`  out  1  high in any state other than IDLE.
- `br_local_busy_i`  in  1  router local port busy; blocks new grants.
- `br_req_o`  out  1  BrLite request to router.
- `br_ack_i`  in  1  BrLite acknowledge from router.
- `br_data_o`  out  brlite_out_t  latched packet of the granted requester.
- `sent_cnt_o`  out  32  count of acknowledged broadcasts; wraps 2^32−1 → 0.

## Operation
- **States:** IDLE, SEND, GAP.
- **Registered outputs:** all outputs are registered. Reset values: `br_req_o`=0, `br_data_o`=0, `ack_o`=0, `grant_o`=0, `busy_o`=0, `sent_cnt_o`=0. Internal state at reset: `ptr`=0, gap counter=0, state=IDLE.
- **IDLE:**
  - Eligible set = `req_i & ~ack_o`. This masks a requester in the cycle its ack is visible, preventing a double send.
  - If the set is non-empty and `br_local_busy_i`=0: pick the first eligible index scanning `ptr`, `ptr+1`, … with wrap mod `N_REQ`.
  - Register `br_data_o`←`data_i[idx]`, `grant_o`←onehot(idx), `br_req_o`←1, and go to SEND.
  - Otherwise stay in IDLE.
- **SEND:**
  - `br_req_o`, `br_data_o` and `grant_o` are held stable; `req_i` and `data_i` are not resampled.
  - On `br_ack_i`=1: `br_req_o`←0, `grant_o`←0, `ack_o[idx]`←1 for one cycle, `ptr`←(idx+1) mod `N_REQ`, `sent_cnt_o`+=1.
  - Next state is GAP with counter←`MIN_GAP`−1 if `MIN_GAP`>0; otherwise IDLE.
- **GAP:** decrement the counter each cycle; go to IDLE on the cycle the counter reads 0. No grants are issued in GAP.
- **`br_ack_i` outside SEND:** ignored.
- **Requester contract:**
  - Hold `req_i` and `data_i` stable until `ack_o` is seen.
  - Drop `req_i` or present a new packet in the cycle after `ack_o`.
- **Withdrawal during SEND:** a requester dropping `req_i` while in SEND does not abort; the latched packet completes and `ack_o` still pulses.
- **Router busy:** `br_local_busy_i` is sampled only in IDLE; it has no effect in SEND.
- **Reset mid-operation:** the in-flight packet is abandoned. `br_req_o` is 0 on the cycle after `rst_i` is sampled high, and no `ack_o` is issued for the abandoned packet.
- **Fairness:** round-robin via `ptr` guarantees that each requester with `req_i` held is granted within `N_REQ` broadcasts.

## Timing
- **Grant latency:** `req_i` eligible in IDLE at cycle t → `br_req_o`=1 and `grant_o` valid at t+1.
- **Completion:** `br_ack_i` sampled at cycle s → `br_req_o`=0 and `ack_o` pulse at s+1.
- **Next grant:** earliest `br_req_o` rise for the next packet is at s+2+`MIN_GAP`. For `MIN_GAP`=0 this is s+2.
- **Ack persistence:** `br_ack_i` is allowed to arrive on the first cycle `br_req_o` is high; the minimum SEND length is 1 cycle.
- **Throughput:** maximum is one broadcast per 2+`MIN_GAP` cycles.

## Test plan
1. **Single requester:**
   - Stimulus: `N_REQ`=3, `MIN_GAP`=2; `req_i`=001 at t0 with payload 0xDEADBEEF; router acks 3 cycles after `br_req_o` rises.
   - Required response: `br_req_o` rises at t0+1; `br_data_o`.payload=0xDEADBEEF; `ack_o`=001 for exactly one cycle; `sent_cnt_o`=1.
2. **Round-robin fairness:**
   - Stimulus: `req_i`=111 held continuously; each requester re-raises after its ack; router acks immediately.
   - Required response: grant order 0,1,2,0,1,2; consecutive `br_req_o` rises spaced exactly 4 cycles apart.
3. **Router busy blocking:**
   - Stimulus: `br_local_busy_i`=1 for 10 cycles while `req_i`=010.
   - Required response: `br_req_o` stays 0; grant for index 1 occurs 1 cycle after busy falls.
4. **No double send:**
   - Stimulus: `MIN_GAP`=0; requester 2 keeps `req_i` high during its `ack_o` cycle, then drops it.
   - Required response: exactly one broadcast; no second `br_req_o` for index 2; `sent_cnt_o`=1.
5. **Reset mid-SEND:**
   - Stimulus: `rst_i`=1 asserted while `br_req_o`=1.
   - Required response: next cycle all outputs are 0, `ptr`=0, no `ack_o`; a stray `br_ack_i` afterwards is ignored.
6. **Counter wrap:**
   - Stimulus: force `sent_cnt_o` to 0xFFFFFFFF, then complete one broadcast.
   - Required response: `sent_cnt_o` reads 0.

Source files
------------

// File: rtl/brlite_tx_arbiter.sv
// Round-robin arbiter sharing the BrLite local output port between N_REQ producers.
// Packet layout (brlite_out_t, 64 bits): {service[7:0], ksvc[7:0], seq_target[7:0], producer[7:0], payload[31:0]}.
module brlite_tx_arbiter #(
    parameter int N_REQ   = 3,
    parameter int MIN_GAP = 2,
    parameter int DATA_W  = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*DATA_W-1:0]   data_i,
    output logic [N_REQ-1:0]          ack_o,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      busy_o,
    input  logic                      br_local_busy_i,
    output logic                      br_req_o,
    input  logic                      br_ack_i,
    output logic [DATA_W-1:0]         br_data_o,
    output logic [31:0]               sent_cnt_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0] GAP_INIT = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'd0;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t              r_state, w_stateNext;
    logic [PTR_W-1:0]    r_ptr, w_ptrNext;
    logic [PTR_W-1:0]    r_idx, w_idxNext;
    logic [7:0]          r_gap, w_gapNext;
    logic [N_REQ-1:0]    r_ack, w_ackNext;
    logic [N_REQ-1:0]    r_grant, w_grantNext;
    logic                r_busy, w_busyNext;
    logic                r_brReq, w_brReqNext;
    logic [DATA_W-1:0]   r_brData, w_brDataNext;
    logic [31:0]         r_sentCnt, w_sentCntNext;

    logic [N_REQ-1:0]    w_eligible;
    logic                w_found;
    logic [PTR_W-1:0]    w_idx;
    int                  w_cand;

    // A requester whose ack is visible this cycle is masked so it cannot win twice.
    assign w_eligible = req_i & ~r_ack;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = int'(r_ptr) + i;
            if (w_cand >= N_REQ) begin
                w_cand = w_cand - N_REQ;
            end
            if (!w_found && w_eligible[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_gap     <= '0;
            r_ack     <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_brReq   <= 1'b0;
            r_brData  <= '0;
            r_sentCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_ptr     <= w_ptrNext;
            r_idx     <= w_idxNext;
            r_gap     <= w_gapNext;
            r_ack     <= w_ackNext;
            r_grant   <= w_grantNext;
            r_busy    <= w_busyNext;
            r_brReq   <= w_brReqNext;
            r_brData  <= w_brDataNext;
            r_sentCnt <= w_sentCntNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found && !br_local_busy_i) begin
                    w_stateNext = S_SEND;
                end
            end
            S_SEND: begin
                if (br_ack_i) begin
                    w_stateNext = (MIN_GAP > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap == 8'd0) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; ack is a pulse so it defaults to zero.
    always_comb begin
        w_ptrNext     = r_ptr;
        w_idxNext     = r_idx;
        w_gapNext     = r_gap;
        w_ackNext     = '0;
        w_grantNext   = r_grant;
        w_brReqNext   = r_brReq;
        w_brDataNext  = r_brData;
        w_sentCntNext = r_sentCnt;
        case (r_state)
            S_IDLE: begin
                if (w_found && !br_local_busy_i) begin
                    w_idxNext          = w_idx;
                    w_grantNext        = '0;
                    w_grantNext[w_idx] = 1'b1;
                    w_brReqNext        = 1'b1;
                    w_brDataNext       = data_i[int'(w_idx)*DATA_W +: DATA_W];
                end
            end
            S_SEND: begin
                if (br_ack_i) begin
                    w_brReqNext      = 1'b0;
                    w_grantNext      = '0;
                    w_ackNext[r_idx] = 1'b1;
                    w_ptrNext        = (r_idx == LAST_IDX) ? '0 : r_idx + PTR_W'(1);
                    w_sentCntNext    = r_sentCnt + 32'd1;
                    w_gapNext        = GAP_INIT;
                end
            end
            S_GAP: begin
                if (r_gap != 8'd0) begin
                    w_gapNext = r_gap - 8'd1;
                end
            end
            default: ;
        endcase
        w_busyNext = (w_stateNext != S_IDLE);
    end

    assign ack_o      = r_ack;
    assign grant_o    = r_grant;
    assign busy_o     = r_busy;
    assign br_req_o   = r_brReq;
    assign br_data_o  = r_brData;
    assign sent_cnt_o = r_sentCnt;

endmodule

// File: tb/tb_brlite_tx_arbiter.sv
// Directed self-checking bench for brlite_tx_arbiter: a MIN_GAP=2 instance and a MIN_GAP=0 instance.
module tb_brlite_tx_arbiter;

    localparam int N  = 3;
    localparam int DW = 64;

    logic            clk;
    logic            rst;

    logic [N-1:0]    req, ack, grant;
    logic [N*DW-1:0] data;
    logic            busy, localBusy, brReq, brAck;
    logic [DW-1:0]   brData;
    logic [31:0]     sentCnt;

    logic [N-1:0]    reqZ, ackZ, grantZ;
    logic [N*DW-1:0] dataZ;
    logic            busyZ, localBusyZ, brReqZ, brAckZ;
    logic [DW-1:0]   brDataZ;
    logic [31:0]     sentCntZ;

    int checks = 0;
    int errors = 0;

    brlite_tx_arbiter #(.N_REQ(N), .MIN_GAP(2), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data),
        .ack_o(ack), .grant_o(grant), .busy_o(busy),
        .br_local_busy_i(localBusy), .br_req_o(brReq), .br_ack_i(brAck),
        .br_data_o(brData), .sent_cnt_o(sentCnt)
    );

    brlite_tx_arbiter #(.N_REQ(N), .MIN_GAP(0), .DATA_W(DW)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(reqZ), .data_i(dataZ),
        .ack_o(ackZ), .grant_o(grantZ), .busy_o(busyZ),
        .br_local_busy_i(localBusyZ), .br_req_o(brReqZ), .br_ack_i(brAckZ),
        .br_data_o(brDataZ), .sent_cnt_o(sentCntZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [DW-1:0] mkPkt(input logic [7:0] svc, input logic [7:0] prod,
                                            input logic [31:0] payload);
        return {svc, 8'h01, 8'h00, prod, payload};
    endfunction

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; data = '0; localBusy = 1'b0; brAck = 1'b0;
        reqZ = '0; dataZ = '0; localBusyZ = 1'b0; brAckZ = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (brReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_brReq: got %b expected 0", brReq); end
        checks++; if (brData !== '0) begin errors++; $display("[TB] FAIL reset_brData: got %h expected 0", brData); end
        checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 000", ack); end
        checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (sentCnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_sentCnt: got %0d expected 0", sentCnt); end
        checks++; if (brReqZ !== 1'b0) begin errors++; $display("[TB] FAIL reset_brReqZ: got %b expected 0", brReqZ); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_requester();
        logic [DW-1:0] pkt;
        pkt = mkPkt(8'h11, 8'h00, 32'hDEADBEEF);
        data[0*DW +: DW] = pkt;
        req = 3'b001;
        @(negedge clk);
        checks++; if (brReq !== 1'b1) begin errors++; $display("[TB] FAIL single_brReq_rise: got %b expected 1", brReq); end
        checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL single_grant: got %b expected 001", grant); end
        checks++; if (brData[31:0] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_payload: got %h expected deadbeef", brData[31:0]); end
        checks++; if (brData !== pkt) begin errors++; $display("[TB] FAIL single_pkt: got %h expected %h", brData, pkt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (brReq !== 1'b1 || ack !== 3'b000) begin errors++; $display("[TB] FAIL single_hold: got req=%b ack=%b expected 1 000", brReq, ack); end
        end
        @(negedge clk);
        brAck = 1'b1;
        @(negedge clk);
        brAck = 1'b0;
        checks++; if (brReq !== 1'b0) begin errors++; $display("[TB] FAIL single_brReq_fall: got %b expected 0", brReq); end
        checks++; if (ack !== 3'b001) begin errors++; $display("[TB] FAIL single_ack: got %b expected 001", ack); end
        checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL single_grant_clear: got %b expected 000", grant); end
        checks++; if (sentCnt !== 32'd1) begin errors++; $display("[TB] FAIL single_sentCnt: got %0d expected 1", sentCnt); end
        req = 3'b000;
        @(negedge clk);
        checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL single_ack_pulse: got %b expected 000", ack); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_after_gap: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        int rises;
        int lastRise;
        int cyc;
        logic prevReq;
        logic [N-1:0] expGrant;
        doReset();
        for (int i = 0; i < N; i++) data[i*DW +: DW] = mkPkt(8'h20, 8'(i), 32'h1000 + i);
        req = 3'b111;
        rises = 0; lastRise = 0; cyc = 0; prevReq = 1'b0;
        while (rises < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (brReq && !prevReq) begin
                expGrant = '0;
                expGrant[rises % N] = 1'b1;
                checks++; if (grant !== expGrant) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %b expected %b", rises, grant, expGrant); end
                if (rises > 0) begin
                    checks++; if (cyc - lastRise !== 4) begin errors++; $display("[TB] FAIL rr_spacing[%0d]: got %0d expected 4", rises, cyc - lastRise); end
                end
                lastRise = cyc;
                rises++;
            end
            prevReq = brReq;
            brAck = brReq;
        end
        checks++; if (rises !== 6) begin errors++; $display("[TB] FAIL rr_timeout: got %0d grants expected 6", rises); end
        @(negedge clk);
        brAck = 1'b0;
        req = 3'b000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_router_busy();
        logic [DW-1:0] pkt;
        pkt = mkPkt(8'h33, 8'h01, 32'hCAFE0001);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_precond_idle: got %b expected 0", busy); end
        data[1*DW +: DW] = pkt;
        localBusy = 1'b1;
        req = 3'b010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (brReq !== 1'b0) begin errors++; $display("[TB] FAIL busy_block[%0d]: got %b expected 0", i, brReq); end
        end
        localBusy = 1'b0;
        @(negedge clk);
        checks++; if (brReq !== 1'b1 || grant !== 3'b010) begin errors++; $display("[TB] FAIL busy_release_grant: got req=%b grant=%b expected 1 010", brReq, grant); end
        checks++; if (brData !== pkt) begin errors++; $display("[TB] FAIL busy_pkt: got %h expected %h", brData, pkt); end
        brAck = 1'b1;
        @(negedge clk);
        brAck = 1'b0;
        checks++; if (ack !== 3'b010) begin errors++; $display("[TB] FAIL busy_ack: got %b expected 010", ack); end
        req = 3'b000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_no_double_send();
        int extraRises;
        dataZ[2*DW +: DW] = mkPkt(8'h44, 8'h02, 32'h0BADF00D);
        reqZ = 3'b100;
        @(negedge clk);
        checks++; if (brReqZ !== 1'b1 || grantZ !== 3'b100) begin errors++; $display("[TB] FAIL nds_grant: got req=%b grant=%b expected 1 100", brReqZ, grantZ); end
        brAckZ = 1'b1;
        @(negedge clk);
        brAckZ = 1'b0;
        checks++; if (ackZ !== 3'b100) begin errors++; $display("[TB] FAIL nds_ack: got %b expected 100", ackZ); end
        checks++; if (brReqZ !== 1'b0) begin errors++; $display("[TB] FAIL nds_brReq_fall: got %b expected 0", brReqZ); end
        @(negedge clk);
        checks++; if (brReqZ !== 1'b0) begin errors++; $display("[TB] FAIL nds_masked: got %b expected 0", brReqZ); end
        reqZ = 3'b000;
        extraRises = 0;
        repeat (5) begin
            @(negedge clk);
            if (brReqZ) extraRises++;
        end
        checks++; if (extraRises !== 0) begin errors++; $display("[TB] FAIL nds_no_resend: got %0d cycles with req expected 0", extraRises); end
        checks++; if (sentCntZ !== 32'd1) begin errors++; $display("[TB] FAIL nds_sentCnt: got %0d expected 1", sentCntZ); end
    endtask

    task automatic test_reset_mid_send();
        data[0*DW +: DW] = mkPkt(8'h55, 8'h00, 32'h55555555);
        req = 3'b001;
        @(negedge clk);
        checks++; if (brReq !== 1'b1) begin errors++; $display("[TB] FAIL rms_precond: got %b expected 1", brReq); end
        rst = 1'b1;
        brAck = 1'b1;
        @(negedge clk);
        checks++; if (brReq !== 1'b0) begin errors++; $display("[TB] FAIL rms_brReq: got %b expected 0", brReq); end
        checks++; if (grant !== 3'b000 || ack !== 3'b000) begin errors++; $display("[TB] FAIL rms_grant_ack: got %b %b expected 000 000", grant, ack); end
        checks++; if (busy !== 1'b0 || brData !== '0) begin errors++; $display("[TB] FAIL rms_busy_data: got %b %h expected 0 0", busy, brData); end
        checks++; if (sentCnt !== 32'd0) begin errors++; $display("[TB] FAIL rms_sentCnt: got %0d expected 0", sentCnt); end
        rst = 1'b0;
        req = 3'b000;
        repeat (2) begin
            @(negedge clk);
            checks++; if (ack !== 3'b000 || brReq !== 1'b0 || sentCnt !== 32'd0) begin errors++; $display("[TB] FAIL rms_stray_ack: got ack=%b req=%b cnt=%0d expected 000 0 0", ack, brReq, sentCnt); end
        end
        brAck = 1'b0;
        data[1*DW +: DW] = mkPkt(8'h56, 8'h01, 32'h66666666);
        data[2*DW +: DW] = mkPkt(8'h57, 8'h02, 32'h77777777);
        req = 3'b110;
        @(negedge clk);
        checks++; if (grant !== 3'b010) begin errors++; $display("[TB] FAIL rms_ptr_zero: got %b expected 010", grant); end
        brAck = 1'b1;
        @(negedge clk);
        brAck = 1'b0;
        checks++; if (ack !== 3'b010) begin errors++; $display("[TB] FAIL rms_ack_after: got %b expected 010", ack); end
        req = 3'b000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_counter_wrap();
        force dut.r_sentCnt = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.r_sentCnt;
        checks++; if (sentCnt !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL wrap_preload: got %h expected ffffffff", sentCnt); end
        data[0*DW +: DW] = mkPkt(8'h66, 8'h00, 32'h12345678);
        req = 3'b001;
        @(negedge clk);
        checks++; if (brReq !== 1'b1) begin errors++; $display("[TB] FAIL wrap_grant: got %b expected 1", brReq); end
        brAck = 1'b1;
        @(negedge clk);
        brAck = 1'b0;
        req = 3'b000;
        checks++; if (sentCnt !== 32'd0) begin errors++; $display("[TB] FAIL wrap_zero: got %h expected 00000000", sentCnt); end
        checks++; if (ack !== 3'b001) begin errors++; $display("[TB] FAIL wrap_ack: got %b expected 001", ack); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_requester();
        test_round_robin();
        test_router_busy();
        test_no_double_send();
        test_reset_mid_send();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
